cov_seq_gen: RTL
================

Name: cov_seq_gen

Overview:
- Parametrised coverage-stimulus target with two parts.
- A registered pattern detector over an IN_W-bit input vector: an all-ones match, plus a masked programmable pattern match with a saturating hit counter.
- A programmable-skip state sequencer with free-run and one-shot modes that emits a wrap pulse.
- Used as a DUT for coverage closure exercises (condition, FSM-state and transition, toggle coverage).

Parameters:
- IN_W, 3: width of in_vec (2..8).
- PATTERN, 3'b011: value compared against in_vec (IN_W bits).
- MASK, 3'b111: bits of in_vec that take part in the pattern compare (1 = compared).
- SEQ_W, 2: sequencer state width (2..4); NSTATES = 2**SEQ_W.
- SKIP_MASK, 4'b0100: bit k set means state k is never visited (NSTATES bits). Bit 0 and the highest bit must be 0.
- CNT_W, 4: hit counter width (2..16).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- in_vec  in  IN_W  condition inputs.
- en  in  1  sequencer advance enable.
- one_shot  in  1  sequencer mode: 0 = free-run, 1 = one-shot. Sampled each cycle.
- start  in  1  restart the sequencer at state 0 and clear seq_done.
- match_all  out  1  registered: all in_vec bits were 1 in the previous cycle.
- match_pat  out  1  registered: ((in_vec ^ PATTERN) & MASK) == 0 in the previous cycle.
- hit_cnt  out  CNT_W  number of cycles match_pat has been 1, saturating.
- seq_state  out  SEQ_W  current sequencer state.
- seq_pulse  out  1  one-cycle pulse after leaving the last state.
- seq_done  out  1  one-shot run complete.

Behaviour:
- Reset: when RST = 1 at a rising edge, all outputs and internal registers go to 0: match_all, match_pat, hit_cnt, seq_state, seq_pulse, seq_done. RST overrides every other input.
- Detector:
  - Latency is 1 cycle; both flags are pure registered functions of the in_vec sampled on the previous edge.
  - Both flags may be 1 simultaneously (e.g. when PATTERN is all ones).
- Hit counter:
  - Increments by 1 on each edge where match_pat is currently 1, so it counts lag the match by one cycle.
  - Holds at 2**CNT_W-1 once reached; never wraps.
  - Cleared only by RST.
- Sequencer state rules:
  - LAST = highest index whose SKIP_MASK bit is 0, i.e. NSTATES-1.
  - next(s) = lowest non-skipped index greater than s; next(LAST) = 0.
  - If seq_state ever holds a skipped index (not reachable in a fault-free design), next = 0 with no pulse.
- Sequencer transitions, one decision per edge, in priority order:
  1. start = 1: seq_state <= 0, seq_done <= 0, seq_pulse <= 0. start wins over en.
  2. en = 0, or seq_done = 1: hold seq_state, seq_pulse <= 0.
  3. en = 1 and seq_state != LAST: seq_state <= next(seq_state), seq_pulse <= 0.
  4. en = 1 and seq_state == LAST: seq_state <= 0, seq_pulse <= 1. If one_shot = 1, also seq_done <= 1.
- seq_pulse is high for exactly one cycle, coincident with seq_state == 0 after the wrap.
- One-shot: after completion the sequencer parks at state 0 with seq_done = 1 and ignores en until start.
- Mode change: switching one_shot 1->0 while seq_done = 1 does not resume; start is still required.
- Defaults: the sequence is 0 -> 1 -> 3 -> 0, with seq_pulse asserted in the cycle after leaving state 3.
- Reset mid-sequence: the next cycle shows state 0, no pulse, done = 0; hit_cnt is lost.

Decomposition:
- Package cov_pkg:
  - Default parameter constants.
  - Function next_state(s, skip_mask) returning the next non-skipped index.
  - Function last_state(skip_mask).
  - Elaboration-time check that SKIP_MASK bit 0 and bit NSTATES-1 are 0 (fatal on violation).
- Sub-module cov_sequencer: en/start/one_shot in; seq_state/seq_pulse/seq_done out.
- Detector and counter live in the top level cov_seq_gen.

Test Plan:
1. Reset: RST = 1 for 2 cycles with random inputs -> every output is 0 on the cycle after the first reset edge and stays 0 while RST is held.
2. Detector: in_vec = 3'b111, then 3'b011, then 3'b001, one per cycle -> (match_all, match_pat) = (1,0), (0,1), (0,0) one cycle later; hit_cnt ends at 1.
3. Saturation: CNT_W = 2, in_vec = 3'b011 held for 6 cycles -> hit_cnt goes 0, 1, 2, 3, 3, 3 (lagging match_pat by one cycle).
4. Free-run default: en = 1 for 7 cycles -> seq_state = 0, 1, 3, 0, 1, 3, 0; seq_pulse = 1 only on each return to 0 after state 3; state 2 never appears.
5. One-shot with SEQ_W = 3, SKIP_MASK = 8'b00101000:
   - en = 1 -> states 0, 1, 2, 4, 6, 7, 0; seq_pulse and seq_done set on the last transition.
   - Further en has no effect.
   - start -> seq_done = 0 and the sequencer re-runs.
6. Collisions:
   - start and en together at state 3 -> state 0 with no pulse.
   - RST asserted at state 1 with en = 1 -> state 0, pulse 0.

Source files
------------

// File: rtl/cov_pkg.sv
// Shared constants, the sequencer action type and skip-mask helper functions
// for the cov_seq_gen coverage-stimulus target.
package cov_pkg;

    localparam int          DEF_IN_W      = 3;
    localparam logic [2:0]  DEF_PATTERN   = 3'b011;
    localparam logic [2:0]  DEF_MASK      = 3'b111;
    localparam int          DEF_SEQ_W     = 2;
    localparam logic [3:0]  DEF_SKIP_MASK = 4'b0100;
    localparam int          DEF_CNT_W     = 4;

    // One decision per clock edge, listed in priority order.
    typedef enum logic [1:0] {
        SEQ_RESTART = 2'd0,
        SEQ_HOLD    = 2'd1,
        SEQ_STEP    = 2'd2,
        SEQ_WRAP    = 2'd3
    } seq_act_t;

    // Lowest non-skipped index above s, or 0 when none exists.
    // A skipped (unreachable) s also recovers to 0.
    function automatic logic [3:0] next_state(input logic [3:0]  s,
                                              input logic [15:0] skip_mask,
                                              input logic [4:0]  nstates);
        logic [3:0] r;
        logic       found;
        r     = 4'd0;
        found = 1'b0;
        if (!skip_mask[s]) begin
            for (int k = 0; k < 16; k++) begin
                if (!found && (k > int'(s)) && (k < int'(nstates)) && !skip_mask[k]) begin
                    r     = 4'(k);
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Highest non-skipped index below nstates.
    function automatic logic [3:0] last_state(input logic [15:0] skip_mask,
                                              input logic [4:0]  nstates);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if ((k < int'(nstates)) && !skip_mask[k]) begin
                r = 4'(k);
            end
        end
        return r;
    endfunction

    // State 0 and the top state must both be reachable.
    function automatic logic skip_mask_ok(input logic [15:0] skip_mask,
                                          input logic [4:0]  nstates);
        return !skip_mask[0] && !skip_mask[4'(nstates - 5'd1)];
    endfunction

endpackage

// File: rtl/cov_seq_gen_if.sv
// Bus bundle for cov_seq_gen: stimulus inputs and detector/sequencer outputs.
interface cov_seq_gen_if #(
    parameter int IN_W  = 3,
    parameter int SEQ_W = 2,
    parameter int CNT_W = 4
);
    logic [IN_W-1:0]  in_vec;
    logic             en;
    logic             one_shot;
    logic             start;
    logic             match_all;
    logic             match_pat;
    logic [CNT_W-1:0] hit_cnt;
    logic [SEQ_W-1:0] seq_state;
    logic             seq_pulse;
    logic             seq_done;

    modport master (
        output in_vec, en, one_shot, start,
        input  match_all, match_pat, hit_cnt, seq_state, seq_pulse, seq_done
    );

    modport slave (
        input  in_vec, en, one_shot, start,
        output match_all, match_pat, hit_cnt, seq_state, seq_pulse, seq_done
    );
endinterface

// File: rtl/cov_sequencer.sv
// Programmable-skip state sequencer with free-run and one-shot modes.
// Emits a one-cycle wrap pulse when leaving the last reachable state.
module cov_sequencer
    import cov_pkg::*;
#(
    parameter int                       SEQ_W     = DEF_SEQ_W,
    parameter logic [(2**SEQ_W)-1:0]    SKIP_MASK = (2**SEQ_W)'(DEF_SKIP_MASK)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             one_shot,
    input  logic             start,
    output logic [SEQ_W-1:0] seq_state,
    output logic             seq_pulse,
    output logic             seq_done
);

    localparam int               NSTATES = 2**SEQ_W;
    localparam logic [4:0]       NST5    = 5'(NSTATES);
    localparam logic [15:0]      SKIP16  = 16'(SKIP_MASK);
    localparam logic [SEQ_W-1:0] LAST    = SEQ_W'(last_state(SKIP16, NST5));

    if (SEQ_W < 2 || SEQ_W > 4) begin : g_bad_width
        $fatal(1, "cov_sequencer: SEQ_W must be in 2..4");
    end
    if (!skip_mask_ok(SKIP16, NST5)) begin : g_bad_skip
        $fatal(1, "cov_sequencer: SKIP_MASK bit 0 and top bit must be 0");
    end

    logic [SEQ_W-1:0] state_q, state_d;
    logic             pulse_q, pulse_d;
    logic             done_q,  done_d;
    seq_act_t         act;

    // State register: synchronous reset clears state, pulse and done.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    // Next-state: pick the highest-priority action, then derive the next values.
    always_comb begin
        act = SEQ_STEP;
        if (start) begin
            act = SEQ_RESTART;
        end else if (!en || done_q) begin
            act = SEQ_HOLD;
        end else if (state_q == LAST) begin
            act = SEQ_WRAP;
        end

        state_d = state_q;
        pulse_d = 1'b0;
        done_d  = done_q;
        case (act)
            SEQ_RESTART: begin
                state_d = '0;
                done_d  = 1'b0;
            end
            SEQ_HOLD: begin
                state_d = state_q;
            end
            SEQ_STEP: begin
                state_d = SEQ_W'(next_state(4'(state_q), SKIP16, NST5));
            end
            SEQ_WRAP: begin
                state_d = '0;
                pulse_d = 1'b1;
                done_d  = one_shot;
            end
            default: begin
                state_d = '0;
            end
        endcase
    end

    // Outputs: straight from the registers, no combinational path from inputs.
    always_comb begin
        seq_state = state_q;
        seq_pulse = pulse_q;
        seq_done  = done_q;
    end

endmodule

// File: rtl/cov_seq_gen.sv
// Coverage-stimulus target: registered all-ones / masked-pattern detector with
// a saturating hit counter, plus a programmable-skip state sequencer.
module cov_seq_gen
    import cov_pkg::*;
#(
    parameter int                       IN_W      = DEF_IN_W,
    parameter logic [IN_W-1:0]          PATTERN   = IN_W'(DEF_PATTERN),
    parameter logic [IN_W-1:0]          MASK      = IN_W'(DEF_MASK),
    parameter int                       SEQ_W     = DEF_SEQ_W,
    parameter logic [(2**SEQ_W)-1:0]    SKIP_MASK = (2**SEQ_W)'(DEF_SKIP_MASK),
    parameter int                       CNT_W     = DEF_CNT_W
) (
    input  logic          CLK,
    input  logic          RST,
    cov_seq_gen_if.slave  bus
);

    if (IN_W < 2 || IN_W > 8) begin : g_bad_in_w
        $fatal(1, "cov_seq_gen: IN_W must be in 2..8");
    end
    if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
        $fatal(1, "cov_seq_gen: CNT_W must be in 2..16");
    end

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             match_all_p1;
    logic             match_pat_p1;
    logic [CNT_W-1:0] hit_cnt_p2;

    // Stage 1: detector flags registered from the sampled input vector.
    always_ff @(posedge CLK) begin
        if (RST) begin
            match_all_p1 <= 1'b0;
            match_pat_p1 <= 1'b0;
        end else begin
            match_all_p1 <= &bus.in_vec;
            match_pat_p1 <= (((bus.in_vec ^ PATTERN) & MASK) == '0);
        end
    end

    // Stage 2: count cycles the registered pattern flag is high, saturating.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_p2 <= '0;
        end else if (match_pat_p1) begin
            hit_cnt_p2 <= sat_inc(hit_cnt_p2);
        end
    end

    assign bus.match_all = match_all_p1;
    assign bus.match_pat = match_pat_p1;
    assign bus.hit_cnt   = hit_cnt_p2;

    cov_sequencer #(
        .SEQ_W     (SEQ_W),
        .SKIP_MASK (SKIP_MASK)
    ) u_seq (
        .CLK       (CLK),
        .RST       (RST),
        .en        (bus.en),
        .one_shot  (bus.one_shot),
        .start     (bus.start),
        .seq_state (bus.seq_state),
        .seq_pulse (bus.seq_pulse),
        .seq_done  (bus.seq_done)
    );

endmodule
